// File: rtl/uart_tx_if.sv
// Parallel-side interface of the UART transmitter: baud tick, start
// strobe and byte in; serial line and status out.
interface uart_tx_if #(
    parameter int SIZE_TRAMA_BIT = 8
);
    logic                      i_tick;
    logic                      i_tx_start;
    logic [SIZE_TRAMA_BIT-1:0] i_data;
    logic                      o_tx;
    logic                      o_tx_busy;
    logic                      o_tx_done;

    // Control logic side: drives the request, watches the line and status.
    modport master (
        output i_tick, i_tx_start, i_data,
        input  o_tx, o_tx_busy, o_tx_done
    );

    // Transmitter side.
    modport slave (
        input  i_tick, i_tx_start, i_data,
        output o_tx, o_tx_busy, o_tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, SIZE_TRAMA_BIT data bits LSB first, optional
// parity bit, SB_TICKS ticks of stop. Every bit phase is counted in 16x
// oversampling ticks shared with the receive path. All outputs are registered.
module uart_tx #(
    parameter int SIZE_TRAMA_BIT   = 8,
    parameter int SIZE_BIT_COUNTER = 3,   // 2**SIZE_BIT_COUNTER >= SIZE_TRAMA_BIT
    parameter int SB_TICKS         = 16,  // 16 = one stop bit, 32 = two
    parameter bit PARITY_EN        = 1'b0,
    parameter bit PARITY_ODD       = 1'b0
) (
    input logic      i_clk,
    input logic      i_reset,
    uart_tx_if.slave bus
);
    // Stop phase may need 32 ticks, which no longer fits in 4 bits.
    localparam int TICK_W = (SB_TICKS > 16) ? 5 : 4;
    localparam logic [TICK_W-1:0]           BIT_LAST  = TICK_W'(15);
    localparam logic [TICK_W-1:0]           STOP_LAST = TICK_W'(SB_TICKS - 1);
    localparam logic [SIZE_BIT_COUNTER-1:0] DATA_LAST = SIZE_BIT_COUNTER'(SIZE_TRAMA_BIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_e;

    state_e                      state_q, state_d;
    logic [TICK_W-1:0]           tick_cnt_q, tick_cnt_d;
    logic [SIZE_BIT_COUNTER-1:0] bit_cnt_q, bit_cnt_d;
    logic [SIZE_TRAMA_BIT-1:0]   shift_q, shift_d;
    logic                        parity_q, parity_d;
    logic                        tx_q, tx_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;

    // Next-state logic, then registered-output values derived from the next state.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can
        // leave one unassigned and infer a latch.
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        parity_d   = parity_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // Ticks are ignored here; the frame timing starts at acceptance.
                if (bus.i_tx_start) begin
                    shift_d    = bus.i_data;
                    parity_d   = (^bus.i_data) ^ PARITY_ODD;
                    tick_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = ST_DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = shift_q >> 1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d = PARITY_EN ? ST_PARITY : ST_STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + SIZE_BIT_COUNTER'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == BIT_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_STOP;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            ST_STOP: begin
                if (bus.i_tick) begin
                    if (tick_cnt_q == STOP_LAST) begin
                        tick_cnt_d = '0;
                        state_d    = ST_IDLE;
                        done_d     = 1'b1;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
            end
            default: begin
                // Unused encodings recover to an idle, high line.
                state_d    = ST_IDLE;
                tick_cnt_d = '0;
                bit_cnt_d  = '0;
            end
        endcase

        // Outputs are looked up from the next state so the registered line
        // changes on the same edge that changes the state.
        busy_d = (state_d != ST_IDLE);
        case (state_d)
            ST_START:  tx_d = 1'b0;
            ST_DATA:   tx_d = shift_d[0];
            ST_PARITY: tx_d = parity_d;
            default:   tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (i_reset) begin
            state_q    <= ST_IDLE;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.o_tx      = tx_q;
    assign bus.o_tx_busy = busy_q;
    assign bus.o_tx_done = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four instances (default, even parity, odd parity, two
// stop bits) share clock, reset, tick and data. A frame-level model predicts
// line/busy/done every clock from ticks counted since acceptance, and a
// behavioural 16x receiver decodes each line back into bytes.
module tb_uart_tx;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick = 1'b0;
    logic [7:0]   data;
    logic [N-1:0] start;

    int tick_per  = 4;
    bit tick_rand = 1'b0;
    int ph        = 0;

    always #5 clk = ~clk;

    // Baud tick: one clock wide, either every tick_per clocks or random.
    always @(negedge clk) begin
        if (tick_rand) begin
            tick = ($urandom_range(0, 2) == 0);
        end else begin
            ph   = (ph + 1 >= tick_per) ? 0 : ph + 1;
            tick = (ph == 0);
        end
    end

    uart_tx_if #(.SIZE_TRAMA_BIT(8)) if0 ();
    uart_tx_if #(.SIZE_TRAMA_BIT(8)) if1 ();
    uart_tx_if #(.SIZE_TRAMA_BIT(8)) if2 ();
    uart_tx_if #(.SIZE_TRAMA_BIT(8)) if3 ();

    assign if0.i_tick = tick;  assign if0.i_tx_start = start[0];  assign if0.i_data = data;
    assign if1.i_tick = tick;  assign if1.i_tx_start = start[1];  assign if1.i_data = data;
    assign if2.i_tick = tick;  assign if2.i_tx_start = start[2];  assign if2.i_data = data;
    assign if3.i_tick = tick;  assign if3.i_tx_start = start[3];  assign if3.i_data = data;

    logic [N-1:0] tx_w, busy_w, done_w;
    assign tx_w   = {if3.o_tx, if2.o_tx, if1.o_tx, if0.o_tx};
    assign busy_w = {if3.o_tx_busy, if2.o_tx_busy, if1.o_tx_busy, if0.o_tx_busy};
    assign done_w = {if3.o_tx_done, if2.o_tx_done, if1.o_tx_done, if0.o_tx_done};

    uart_tx dut0 (.i_clk(clk), .i_reset(rst), .bus(if0.slave));
    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (.i_clk(clk), .i_reset(rst), .bus(if1.slave));
    uart_tx #(.PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut2 (.i_clk(clk), .i_reset(rst), .bus(if2.slave));
    uart_tx #(.SB_TICKS(32)) dut3 (.i_clk(clk), .i_reset(rst), .bus(if3.slave));

    int total, bad, cyc;
    logic last_tk;

    // Frame-level model state per instance.
    bit         m_busy [N];
    bit         m_done [N];
    int         m_n    [N];
    logic [7:0] m_byte [N];

    // Behavioural receiver state per instance.
    int         rx_st [N], rx_t [N], rx_k [N], rx_cnt [N], rx_err [N], done_cnt [N];
    logic [7:0] rx_buf [N], rx_last [N];
    logic       last_tx [N];

    function automatic int pen_of(input int i);  return (i == 1 || i == 2) ? 1 : 0; endfunction
    function automatic int odd_of(input int i);  return (i == 2) ? 1 : 0;           endfunction
    function automatic int sb_of(input int i);   return (i == 3) ? 32 : 16;         endfunction
    function automatic int frame_len(input int i);
        return (1 + 8 + pen_of(i)) * 16 + sb_of(i);
    endfunction

    // Line level during the tick interval n (ticks counted since acceptance).
    function automatic logic line_at(input int i, input int n, input logic [7:0] b);
        if (n < 16)                         return 1'b0;
        if (n < 144)                        return b[(n - 16) / 16];
        if (pen_of(i) != 0 && n < 160)      return (^b) ^ (odd_of(i) != 0);
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample inputs at the edge, outputs 1 time unit later, then
    // advance the model and the receivers and compare all instances.
    task automatic step();
        logic         tk_s, rst_s;
        logic [7:0]   d_s;
        logic [N-1:0] s_s;
        logic [2:0]   exp_v;
        @(posedge clk);
        tk_s = tick; rst_s = rst; d_s = data; s_s = start;
        #1;
        cyc++;
        last_tk = tk_s;
        for (int i = 0; i < N; i++) begin
            m_done[i] = 1'b0;
            if (rst_s) begin
                m_busy[i] = 1'b0;
                m_n[i]    = 0;
            end else if (!m_busy[i]) begin
                if (s_s[i]) begin
                    m_busy[i] = 1'b1; m_n[i] = 0; m_byte[i] = d_s;
                end
            end else if (tk_s) begin
                m_n[i]++;
                if (m_n[i] == frame_len(i)) begin
                    m_busy[i] = 1'b0; m_done[i] = 1'b1;
                end
            end
            exp_v = {m_busy[i] ? line_at(i, m_n[i], m_byte[i]) : 1'b1, m_busy[i], m_done[i]};
            check($sformatf("u%0d cyc%0d {tx,busy,done}", i, cyc),
                  {29'd0, tx_w[i], busy_w[i], done_w[i]}, {29'd0, exp_v});

            if (rst_s) begin
                rx_st[i] = 0;
            end else begin
                case (rx_st[i])
                    0: if (last_tx[i] == 1'b0) begin rx_st[i] = 1; rx_t[i] = 0; end
                    1: if (tk_s) begin
                        if (rx_t[i] == 7) begin
                            rx_st[i] = (last_tx[i] == 1'b0) ? 2 : 0; rx_t[i] = 0; rx_k[i] = 0;
                        end else rx_t[i]++;
                    end
                    2: if (tk_s) begin
                        if (rx_t[i] == 15) begin
                            rx_t[i]   = 0;
                            rx_buf[i] = {last_tx[i], rx_buf[i][7:1]};
                            if (rx_k[i] == 7) rx_st[i] = (pen_of(i) != 0) ? 3 : 4;
                            else rx_k[i]++;
                        end else rx_t[i]++;
                    end
                    3: if (tk_s) begin
                        if (rx_t[i] == 15) begin
                            rx_t[i] = 0;
                            if (last_tx[i] !== ((^rx_buf[i]) ^ (odd_of(i) != 0))) rx_err[i]++;
                            rx_st[i] = 4;
                        end else rx_t[i]++;
                    end
                    default: if (tk_s) begin
                        if (rx_t[i] == 15) begin
                            if (last_tx[i] !== 1'b1) rx_err[i]++;
                            rx_cnt[i]++; rx_last[i] = rx_buf[i]; rx_st[i] = 0;
                        end else rx_t[i]++;
                    end
                endcase
            end
            last_tx[i] = tx_w[i];
            if (done_w[i]) done_cnt[i]++;
        end
    endtask

    task automatic wait_idle(input logic [N-1:0] mask, input int bound, input string tag);
        int k;
        for (k = 0; k < bound; k++) begin
            step();
            if ((busy_w & mask) == '0) break;
        end
        check({tag, " idle within bound"}, 32'(k < bound), 32'd1);
    endtask

    initial begin
        logic [9:0] seq_a5;
        logic [7:0] lb [5];
        logic [7:0] b;
        int done_at, busy_n, dn, base_d, base_r, ntk, len1, len2;
        logic par1, par2;

        total = 0; bad = 0; cyc = 0;
        rst = 1'b1; start = '0; data = '0;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0; m_done[i] = 1'b0; m_n[i] = 0; m_byte[i] = '0;
            rx_st[i] = 0; rx_t[i] = 0; rx_k[i] = 0; rx_cnt[i] = 0; rx_err[i] = 0;
            done_cnt[i] = 0; rx_buf[i] = '0; rx_last[i] = '0; last_tx[i] = 1'b1;
        end
        step(); step();
        rst = 1'b0;
        check("reset tx", {31'd0, tx_w[0]}, 32'd1);
        check("reset busy", {31'd0, busy_w[0]}, 32'd0);
        check("reset done", {31'd0, done_w[0]}, 32'd0);
        step(); step();

        // 0xA5, tick every 4 clocks, acceptance on a tick edge.
        for (int k = 0; k < 8 && ph != tick_per - 1; k++) step();
        seq_a5 = {1'b1, 8'hA5, 1'b0};
        base_r = rx_cnt[0];
        data = 8'hA5; start[0] = 1'b1; step(); start[0] = 1'b0;
        check("A5 latency tx low", {31'd0, tx_w[0]}, 32'd0);
        check("A5 latency busy", {31'd0, busy_w[0]}, 32'd1);
        done_at = -1; busy_n = 1; dn = 0;
        for (int k = 1; k <= 700; k++) begin
            step();
            if (busy_w[0]) busy_n++;
            if (done_w[0]) begin dn++; if (done_at < 0) done_at = k; end
            if ((k % 64) == 32 && k < 640)
                check($sformatf("A5 bit %0d", k / 64), {31'd0, tx_w[0]}, {31'd0, seq_a5[k / 64]});
        end
        check("A5 done at 640", done_at, 640);
        check("A5 busy clocks", busy_n, 640);
        check("A5 done pulses", dn, 1);
        check("A5 rx count", rx_cnt[0] - base_r, 1);
        check("A5 rx byte", {24'd0, rx_last[0]}, 32'hA5);

        // Start held high: 0x00 then 0xFF back to back.
        base_d = done_cnt[0]; base_r = rx_cnt[0];
        data = 8'h00; start[0] = 1'b1; step(); data = 8'hFF;
        for (int k = 0; k < 1000; k++) begin
            step();
            if (done_w[0]) break;
        end
        check("b2b first done", {31'd0, done_w[0]}, 32'd1);
        check("b2b first byte", {24'd0, rx_last[0]}, 32'h00);
        step();
        check("b2b restart tx low", {31'd0, tx_w[0]}, 32'd0);
        check("b2b restart busy", {31'd0, busy_w[0]}, 32'd1);
        start[0] = 1'b0;
        wait_idle(4'b0001, 1000, "b2b");
        for (int k = 0; k < 700; k++) step();
        check("b2b done pulses", done_cnt[0] - base_d, 2);
        check("b2b rx count", rx_cnt[0] - base_r, 2);
        check("b2b second byte", {24'd0, rx_last[0]}, 32'hFF);

        // Parity even/odd on 0xA5.
        data = 8'hA5; start[2:1] = 2'b11; step(); start = '0;
        ntk = 0; len1 = -1; len2 = -1; par1 = 1'bx; par2 = 1'bx;
        for (int k = 0; k < 1000 && (len1 < 0 || len2 < 0); k++) begin
            step();
            if (last_tk) begin
                ntk++;
                if (ntk == 152) begin par1 = tx_w[1]; par2 = tx_w[2]; end
            end
            if (done_w[1] && len1 < 0) len1 = ntk;
            if (done_w[2] && len2 < 0) len2 = ntk;
        end
        check("even parity bit", {31'd0, par1}, 32'd0);
        check("odd parity bit", {31'd0, par2}, 32'd1);
        check("even frame ticks", len1, 176);
        check("odd frame ticks", len2, 176);
        check("even rx byte", {24'd0, rx_last[1]}, 32'hA5);
        check("odd rx byte", {24'd0, rx_last[2]}, 32'hA5);

        // Start during DATA of a 0x81 frame is dropped.
        base_d = done_cnt[0]; base_r = rx_cnt[0];
        data = 8'h81; start[0] = 1'b1; step(); start[0] = 1'b0;
        for (int k = 0; k < 200; k++) step();
        data = 8'h3C; start[0] = 1'b1; step(); start[0] = 1'b0;
        wait_idle(4'b0001, 1000, "busy start");
        for (int k = 0; k < 700; k++) step();
        check("busy start done pulses", done_cnt[0] - base_d, 1);
        check("busy start rx count", rx_cnt[0] - base_r, 1);
        check("busy start rx byte", {24'd0, rx_last[0]}, 32'h81);
        check("busy start line high", {31'd0, tx_w[0]}, 32'd1);

        // Reset in the middle of bit 4, then a clean 0x5A.
        data = 8'($urandom); start[0] = 1'b1; step(); start[0] = 1'b0;
        for (int k = 0; k < 1000 && m_n[0] < 88; k++) step();
        rst = 1'b1; step(); rst = 1'b0;
        check("mid reset tx", {31'd0, tx_w[0]}, 32'd1);
        check("mid reset busy", {31'd0, busy_w[0]}, 32'd0);
        check("mid reset done", {31'd0, done_w[0]}, 32'd0);
        base_r = rx_cnt[0];
        data = 8'h5A; start[0] = 1'b1; step(); start[0] = 1'b0;
        wait_idle(4'b0001, 1000, "after reset");
        for (int k = 0; k < 40; k++) step();
        check("after reset rx count", rx_cnt[0] - base_r, 1);
        check("after reset rx byte", {24'd0, rx_last[0]}, 32'h5A);

        // Loopback bytes, one and two stop bits.
        lb = '{8'h00, 8'h55, 8'hAA, 8'hFF, 8'h7E};
        for (int j = 0; j < 5; j++) begin
            data = lb[j]; start = 4'b1001; step(); start = '0;
            wait_idle(4'b1001, 1000, "loopback");
            for (int k = 0; k < 20; k++) step();
            check($sformatf("loop sb16 %02h", lb[j]), {24'd0, rx_last[0]}, {24'd0, lb[j]});
            check($sformatf("loop sb32 %02h", lb[j]), {24'd0, rx_last[3]}, {24'd0, lb[j]});
        end

        // Random bytes with irregular tick spacing on every instance.
        tick_rand = 1'b1;
        for (int j = 0; j < 6; j++) begin
            b = 8'($urandom);
            data = b; start = '1; step(); start = '0;
            wait_idle('1, 3000, "random");
            for (int k = 0; k < 10; k++) step();
            for (int i = 0; i < N; i++)
                check($sformatf("random u%0d %02h", i, b), {24'd0, rx_last[i]}, {24'd0, b});
        end

        for (int i = 0; i < N; i++)
            check($sformatf("u%0d rx framing/parity errors", i), rx_err[i], 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default, with optional parity bit and configurable stop length.
- Consumes the shared 16x-oversampling baud tick used by the UART receive path.
- Sits between the interface/ALU control logic (parallel byte + start strobe) and the TX pin.
- Counterpart of the team's UART receiver; frames it emits must be received error-free by that block.

Parameters:
- SIZE_TRAMA_BIT, 8, data bits per frame.
- SIZE_BIT_COUNTER, 3, data-bit counter width; must satisfy 2^SIZE_BIT_COUNTER >= SIZE_TRAMA_BIT.
- SB_TICKS, 16, stop-bit duration in ticks (16 = 1 stop bit, 32 = 2 stop bits).
- PARITY_EN, 0, 1 = insert a parity bit after the data bits.
- PARITY_ODD, 0, parity sense when PARITY_EN=1 (0 = even, 1 = odd).

Ports:
- i_clk  in  1  system clock
- i_reset  in  1  reset
- i_tick  in  1  baud tick, 16 per bit period, one i_clk wide
- i_tx_start  in  1  request to send i_data; level-sampled
- i_data  in  SIZE_TRAMA_BIT  byte to transmit
- o_tx  out  1  serial line, idle high
- o_tx_busy  out  1  high while a frame is in progress
- o_tx_done  out  1  one-clk pulse at end of the stop bit

Behaviour:
- Reset: i_reset, synchronous, active-high; clock i_clk.
  - On reset: state=IDLE, o_tx=1, o_tx_busy=0, o_tx_done=0, tick counter=0, bit counter=0, shift register=0.
  - Reset mid-frame aborts the frame; o_tx is high after the next edge.
- Registered outputs: o_tx, o_tx_busy and o_tx_done are all registers, with no combinational path from inputs.
- Tick counter: 4 bits, plus a 5-bit path when SB_TICKS > 16.
  - Advances only on clocks with i_tick=1.
  - A bit phase ends on the tick where count == limit-1; the counter then clears.
- IDLE:
  - o_tx=1, o_tx_busy=0.
  - If i_tx_start=1: latch i_data into the shift register, compute parity from i_data, clear counters, go to START.
  - i_tick is ignored.
- START:
  - o_tx=0, o_tx_busy=1.
  - After 16 ticks, go to DATA with bit counter=0.
- DATA:
  - o_tx = shift[0], sent LSB first.
  - On the 16th tick, shift right by one.
  - If bit counter == SIZE_TRAMA_BIT-1: go to PARITY if PARITY_EN=1, else STOP.
  - Otherwise increment the bit counter.
- PARITY (PARITY_EN=1 only):
  - o_tx = (^data) XOR PARITY_ODD.
  - After 16 ticks, go to STOP.
- STOP:
  - o_tx=1.
  - After SB_TICKS ticks, go to IDLE and set o_tx_done=1 for exactly one clock.
- Frame length: (1 + SIZE_TRAMA_BIT + PARITY_EN)*16 + SB_TICKS ticks. Default: 160 ticks.
- Start request handling:
  - i_tx_start while busy is ignored; the data is not queued.
  - i_data changes after acceptance do not affect the frame in flight.
- Back-to-back frames:
  - The o_tx_done cycle is an IDLE cycle, so i_tx_start=1 in that cycle is accepted.
  - o_tx goes low on the next edge; zero idle gap is legal.
- Latency: o_tx falls on the first i_clk edge at which i_tx_start=1 is sampled in IDLE.
- Illegal state encoding: force IDLE, o_tx=1, o_tx_done=0.

Test Plan:
- Tick every 4 clks, send i_data=0xA5 with default parameters.
  - o_tx sequence, 64 clks per bit: 0, 1,0,1,0,0,1,0,1, 1.
  - o_tx_done pulses once, 640 clks after acceptance.
  - o_tx_busy is high for exactly those 640 clks.
- Hold i_tx_start=1 continuously with i_data=0x00 then 0xFF.
  - Two contiguous frames with no idle gap between stop and next start.
  - Exactly two o_tx_done pulses.
- PARITY_EN=1, PARITY_ODD=0, send 0xA5 → parity bit 0; PARITY_ODD=1 → parity bit 1.
  - Frame is 176 ticks in both cases.
- Pulse i_tx_start with i_data=0x3C during the DATA phase of a 0x81 frame.
  - The 0x81 frame completes unchanged.
  - No second frame is sent; o_tx stays high afterwards.
- Assert i_reset for one clk in the middle of bit 4.
  - Next cycle: o_tx=1, o_tx_busy=0, o_tx_done=0.
  - A new 0x5A request is then transmitted correctly.
- Loopback o_tx to the team's UART receiver sharing the same i_tick, for bytes 0x00, 0x55, 0xAA, 0xFF, 0x7E.
  - The receiver flags done with a matching buffer for each byte.
  - SB_TICKS=32 also passes.
